// File: rtl/hazard_sched_unit.sv
// hazard_sched_unit: operand forwarding, load-use/branch hazards and multi-cycle execute sequencing
module hazard_sched_unit (
  input  logic       clk,
  input  logic       srst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       res_src_e,
  input  logic       pc_src_e,
  input  logic       mc_start_e,
  input  logic [3:0] mc_cycles_e,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_d,
  output logic       flush_e,
  output logic       bubble_m,
  output logic       mc_capture,
  output logic       mc_busy,
  output logic       mc_done
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, n;
  logic       start_long, idle, on, go, lwstall, mc_stall;
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    n          = mc_cycles_e == 4'd0 ? 4'd1 : mc_cycles_e;
    start_long = mc_start_e && n > 4'd1;
    idle       = state_q == IDLE;
    state_d    = pc_src_e ? IDLE : idle ? (start_long ? BUSY : IDLE) : (cnt_q == 4'd0 ? IDLE : BUSY);
    cnt_d      = pc_src_e ? 4'd0 : idle ? (start_long ? n - 4'd2 : 4'd0) : (cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1);
  end
  always_comb begin
    on         = !srst;
    go         = on && !pc_src_e;
    lwstall    = on && res_src_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    mc_stall   = go && (idle ? start_long : cnt_q != 4'd0);
    forwardAE  = !on ? 2'b00 : (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e) ? 2'b10 :
                 (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) ? 2'b01 : 2'b00;
    forwardBE  = !on ? 2'b00 : (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e) ? 2'b10 :
                 (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) ? 2'b01 : 2'b00;
    stall_f    = mc_stall || lwstall;
    stall_d    = mc_stall || lwstall;
    stall_e    = mc_stall;
    bubble_m   = mc_stall;
    flush_d    = on && pc_src_e;
    flush_e    = !mc_stall && (lwstall || (on && pc_src_e));
    mc_capture = go && idle && mc_start_e;
    mc_busy    = go && (idle ? start_long : 1'b1);
    mc_done    = go && (idle ? mc_start_e && n == 4'd1 : cnt_q == 4'd0);
  end
endmodule

// File: tb/tb_hazard_sched_unit.sv
// tb_hazard_sched_unit: scoreboard bench against a cycle-occupancy reference model
module tb_hazard_sched_unit;
  logic       clk = 0;
  logic       srst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w, res_src_e, pc_src_e, mc_start_e;
  logic [3:0] mc_cycles_e;
  logic [1:0] forwardAE, forwardBE;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, mc_capture, mc_busy, mc_done;
  logic [12:0] sb[$];
  int compared = 0, mismatched = 0, cyc = 0, m_left = 0;
  hazard_sched_unit dut (
    .clk(clk), .srst(srst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .res_src_e(res_src_e), .pc_src_e(pc_src_e), .mc_start_e(mc_start_e), .mc_cycles_e(mc_cycles_e),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .flush_d(flush_d), .flush_e(flush_e), .bubble_m(bubble_m),
    .mc_capture(mc_capture), .mc_busy(mc_busy), .mc_done(mc_done)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic clr();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {reg_write_m, reg_write_w, res_src_e, pc_src_e, mc_start_e, srst} = '0;
    mc_cycles_e = 0;
  endtask
  task automatic step();
    logic [12:0] e;
    int cur, n;
    logic first, lw, mcs;
    assert (srst || !(pc_src_e && (mc_start_e || m_left > 0))) else $error("illegal pc_src_e during multi-cycle op");
    assert (srst || !(pc_src_e && res_src_e)) else $error("illegal pc_src_e with load in execute");
    if (srst) begin
      e = '0;
      m_left = 0;
    end else begin
      n = mc_cycles_e == 0 ? 1 : int'(mc_cycles_e);
      lw = res_src_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      first = !pc_src_e && m_left == 0 && mc_start_e;
      cur = pc_src_e ? 0 : m_left > 0 ? m_left : first ? n : 0;
      mcs = cur > 1;
      e = {fwd(rs1_e), fwd(rs2_e), mcs | lw, mcs | lw, mcs, pc_src_e,
           !mcs && (lw || pc_src_e), mcs, first, cur > 1 || (cur == 1 && !first), cur == 1};
      m_left = cur > 0 ? cur - 1 : 0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [12:0] e, got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = {forwardAE, forwardBE, stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, mc_capture, mc_busy, mc_done};
        compared++;
        if (got !== e) begin
          mismatched++;
          $display("FAIL outputs cyc=%0d got=%b exp=%b (fA fB sf sd se fd fe bm cap busy done)", cyc, got, e);
        end
        cyc++;
      end
    end
  end
  initial begin
    clr();
    srst = 1;
    @(posedge clk);
    #1;
    rs1_e = 5; rd_m = 5; reg_write_m = 1; res_src_e = 1; rd_e = 3; rs1_d = 3; mc_start_e = 1; mc_cycles_e = 4;
    step(); step();
    clr();
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; step();
    rs1_e = 0; step();
    rs2_e = 5; reg_write_m = 0; step();
    rd_m = 0; reg_write_m = 1; rs1_e = 0; rs2_e = 0; step();
    clr();
    res_src_e = 1; rd_e = 7; rs2_d = 7; step();
    res_src_e = 0; step();
    res_src_e = 1; rd_e = 0; rs2_d = 0; step();
    clr(); pc_src_e = 1; step();
    clr(); mc_start_e = 1; mc_cycles_e = 4; step();
    mc_start_e = 0; repeat (4) step();
    mc_start_e = 1; mc_cycles_e = 0; step();
    mc_cycles_e = 1; step();
    mc_cycles_e = 3; repeat (6) step();
    clr(); step();
    mc_start_e = 1; mc_cycles_e = 8; step();
    mc_start_e = 0; step();
    srst = 1; res_src_e = 1; rd_e = 2; rs1_d = 2; step();
    clr(); step(); step();
    mc_start_e = 1; mc_cycles_e = 2; res_src_e = 1; rd_e = 4; rs1_d = 4; step();
    clr(); step();
    for (int i = 0; i < 3000; i++) begin
      srst = $urandom_range(0, 39) == 0;
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
      reg_write_m = 1'($urandom_range(0, 1)); reg_write_w = 1'($urandom_range(0, 1));
      res_src_e = $urandom_range(0, 2) == 0;
      mc_start_e = $urandom_range(0, 3) == 0;
      mc_cycles_e = 4'($urandom_range(0, 15));
      pc_src_e = m_left == 0 && !mc_start_e && !res_src_e && $urandom_range(0, 5) == 0;
      step();
    end
    clr();
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_sched_unit.md
HAZARD_SCHED_UNIT -- requirements
Module: hazard_sched_unit

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: srst  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: rs1_d, rs2_d  in  5 each  source registers in decode.
REQ-004 SHALL provide: rs1_e, rs2_e, rd_e  in  5 each  source and destination registers in execute.
REQ-005 SHALL provide: rd_m, rd_w  in  5 each  destination registers in memory and writeback.
REQ-006 SHALL provide: reg_write_m, reg_write_w  in  1 each  write enables in memory and writeback.
REQ-007 SHALL provide: res_src_e  in  1  load in execute (result_src_e[0]).
REQ-008 SHALL provide: pc_src_e  in  1  taken branch or jump in execute.
REQ-009 SHALL provide: mc_start_e  in  1  execute holds a multi-cycle op.
REQ-010 SHALL provide: mc_cycles_e  in  4  total execute cycles N for that op; 0 is treated as 1.
REQ-011 SHALL provide: forwardAE, forwardBE  out  2 each  operand mux selects: 00 register file, 01 result_w, 10 alu_result_m.
REQ-012 SHALL provide: stall_f, stall_d, stall_e  out  1 each  hold the PC, the F/D register and the D/E register.
REQ-013 SHALL provide: flush_d, flush_e  out  1 each  clear the F/D and D/E registers to a bubble.
REQ-014 SHALL provide: bubble_m  out  1  force a bubble into the E/M register.
REQ-015 SHALL provide: mc_capture  out  1  one-cycle operand latch pulse for the multi-cycle unit.
REQ-016 SHALL provide: mc_busy, mc_done  out  1 each  multi-cycle op in progress; final execute cycle.

Function
REQ-017 forwardAE SHALL be 10 if reg_write_m, rd_m!=0 and rd_m==rs1_e; else 01 if reg_write_w, rd_w!=0 and rd_w==rs1_e; else 00. forwardBE SHALL follow the same rule using rs2_e.
REQ-018 Memory-stage forwarding SHALL take priority over writeback forwarding, and register x0 SHALL never be forwarded.
REQ-019 Load-use stall (lwstall) SHALL be res_src_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
REQ-020 lwstall SHALL assert stall_f, stall_d and flush_e in the same cycle, combinationally.
REQ-021 pc_src_e SHALL assert flush_d and flush_e in the same cycle.
REQ-022 The FSM SHALL have two states, IDLE and BUSY, with a 4-bit down-counter cnt. N = max(mc_cycles_e, 1).
REQ-023 In IDLE with mc_start_e=1: mc_capture=1.
- If N==1: mc_done=1, no stall, remain IDLE.
- If N>1: stall_f=stall_d=stall_e=bubble_m=1 and mc_busy=1; at the next edge cnt<=N-2 and state<=BUSY.
REQ-024 In BUSY with cnt!=0: stall_f=stall_d=stall_e=bubble_m=mc_busy=1, and cnt decrements each cycle.
REQ-025 In BUSY with cnt==0: mc_busy=1, mc_done=1, no stalls, bubble_m=0; next state IDLE.
REQ-026 Total execute occupancy SHALL be exactly N cycles, and the op SHALL advance to M in the cycle mc_done=1.
REQ-027 In BUSY, mc_start_e and mc_cycles_e SHALL be ignored; a new op in E the cycle after mc_done SHALL start a new sequence from IDLE.
REQ-028 Back-to-back multi-cycle ops SHALL incur no idle cycle between them.
REQ-029 Any multi-cycle stall (REQ-023 to REQ-025) SHALL override lwstall; flush_e SHALL NOT assert while stall_e=1.
REQ-030 pc_src_e=1 together with (mc_start_e=1 or state==BUSY) is illegal; the bench SHALL flag it with an assertion; the RTL SHALL give flush priority and return to IDLE.
REQ-031 res_src_e=1 together with pc_src_e=1 is illegal; flush outputs SHALL still follow REQ-021.
REQ-032 All stall, flush and forward outputs SHALL be combinational from inputs, state and cnt; only the state and cnt registers are sequential.

Reset
REQ-033 srst=1 at a clock edge SHALL set state<=IDLE and cnt<=0, including mid-BUSY, abandoning the op.
REQ-034 While srst=1, all outputs SHALL be driven 0.
REQ-035 The first cycle after srst deasserts SHALL behave as IDLE.

Verification
REQ-036 The bench SHALL cover each scenario below with the stated response.
- rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 -> forwardAE=10. rs1_e=0 -> forwardAE=00.
- res_src_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle. Same stimulus with rd_e=0 -> all 0.
- pc_src_e=1 -> flush_d=flush_e=1 with no stall.
- mc_start_e=1, mc_cycles_e=4 -> mc_capture in cycle 0; stall_e=bubble_m=1 in cycles 0-2; mc_done=1 in cycle 3; mc_busy=1 in cycles 0-3; IDLE in cycle 4.
- mc_cycles_e=0 and mc_cycles_e=1 -> mc_done=1 in cycle 0, no stall. Two 3-cycle ops back-to-back -> mc_done in cycles 2 and 5.
- srst pulse in cycle 2 of an 8-cycle op -> all outputs 0 during reset; IDLE with no stalls in the next cycle.
